mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single-port datapath RAM between the CPU datapath (port C) and a DMA/console loader (port D). Each access is single-beat and granted for exactly one cycle. Port D may lock the bus for bursts, bounded by a fairness counter. The block drives the RAM address, write-enable, byte and data-in lines, and gives the CPU a wait signal that freezes its cycle counter.

Parameters:
MAX_BURST, 4, maximum consecutive locked D grants while C is requesting (1..15)
D_FIRST, 1, from IDLE with both requesting: 1 = D wins, 0 = C wins

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
c_req  in  1  CPU access request; held, with c_addr/c_we/c_byte/c_wdata stable, until c_ack
c_addr  in  16  CPU address
c_we  in  1  CPU write
c_byte  in  1  CPU byte access
c_wdata  in  16  CPU write data
c_ack  out  1  CPU access performed this cycle
c_wait  out  1  c_req & ~c_ack; stalls datapath cycle counter
d_req  in  1  DMA request (same hold rule)
d_lock  in  1  DMA requests back-to-back grants
d_addr  in  16  DMA address
d_we  in  1  DMA write
d_byte  in  1  DMA byte access
d_wdata  in  16  DMA write data
d_ack  out  1  DMA access performed this cycle
rdata  out  16  ram_dout passthrough, valid when either ack = 1
ram_addr  out  16  RAM address
ram_we  out  1  RAM write enable
ram_byte  out  1  RAM byte mode
ram_din  out  16  RAM write data
ram_dout  in  16  RAM read data (combinational on ram_addr)

Behaviour:
- Clock is clk; reset is synchronous, active-high. On reset: state = IDLE, burst_cnt = 0, c_ack = d_ack = 0, ram_we = 0, ram_addr = 0, ram_byte = 0, ram_din = 0.
- State register owner ∈ {IDLE, GC, GD}; shared 2-bit encoding. It is registered, so grant latency is 1 cycle: req sampled high at edge N gives ack in cycle N+1.
- In GC: the RAM mux selects the C signals, ram_we = c_we, c_ack = 1. GD is the same with the D signals. In IDLE: ram_we = 0, ram_addr = 0, no ack.
- A write completes at the clk edge that ends the ack cycle. A read's rdata is valid during the ack cycle; the requester samples it at that edge.
- During the ack cycle the owner's req still refers to the current access. The next-state logic ignores it, except for GD with d_lock = 1.
- Next state from IDLE: only c_req gives GC; only d_req gives GD; both give GD if D_FIRST = 1, else GC; neither stays IDLE.
- From GC: d_req gives GD, else IDLE. Back-to-back C accesses therefore take 2 cycles each.
- From GD with d_lock = 1 and d_req = 1: if c_req = 1 and burst_cnt == MAX_BURST-1, go to GC and clear burst_cnt. Otherwise stay in GD and increment burst_cnt.
- From GD otherwise: c_req gives GC, else IDLE.
- burst_cnt rules:
  - Clears when leaving GD or on any GD cycle with c_req = 0. C is not starved only if it is actually waiting.
  - Width is clog2(MAX_BURST)+1 bits and it never wraps.
- Fairness bound: C waits at most MAX_BURST+1 cycles after asserting c_req.
- The owner dropping req during its ack cycle is legal. Asserting req without holding the access fields stable is a protocol violation; the bench flags it with an assertion.
- Reset mid-access: the access in the current ack cycle is abandoned. A write in progress is suppressed only if reset is high at that edge, so the write-enable is gated by ~reset. The requester must re-issue.
- c_ack and d_ack are never both 1 (assertion).

Decomposition:
- Shared package: owner-state encoding (IDLE = 0, GC = 1, GD = 2) and the RAM-port field widths (ADDR_W = 16, DATA_W = 16).
- One natural sub-module, mem_arb_mux: the purely combinational port-select mux for ram_* and the acks, driven by owner.
- The FSM and burst counter stay in mem_arbiter.

Test Plan:
- Reset, then c_req = 1 reading 0o001000 (RAM holds 0o012737): c_ack rises in cycle 1, rdata = 0o012737; c_wait = 1 in cycle 0 only.
- C write to 0o000100 with data 0o177777, byte = 1: RAM low byte becomes 0o377 and high byte is unchanged; ram_we high for exactly 1 cycle.
- Both request from IDLE with D_FIRST = 1: d_ack in cycle 1, then c_ack in cycle 2; no overlap.
- d_lock = 1 with continuous d_req, c_req held, MAX_BURST = 4: d_ack in cycles 1–4, c_ack in cycle 5, D resumes in cycle 6.
- d_lock = 1 with no C request: d_ack every cycle for 20 cycles; burst_cnt stays 0.
- Reset asserted during a GD write cycle: RAM unchanged; outputs at reset values the next cycle; d_ack reissued 1 cycle after reset drops.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg : owner encoding and RAM-port widths for the RAM arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GC   = 2'd1,
    GD   = 2'd2
  } owner_e;

  // Counter must hold MAX_BURST-1 with headroom so it can saturate, not wrap.
  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_mux.sv
// ============================================================================
// mem_arb_mux : combinational RAM-port select and acknowledge decode by owner
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arb_mux
  import mem_arbiter_pkg::*;
(
  input  owner_e            owner,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_we,
  input  logic              c_byte,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_byte,
  output logic [DATA_W-1:0] ram_din,
  output logic              c_ack,
  output logic              d_ack
);

  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_byte = 1'b0;
    ram_din  = '0;
    c_ack    = 1'b0;
    d_ack    = 1'b0;
    case (owner)
      GC: begin
        ram_addr = c_addr;
        ram_we   = c_we;
        ram_byte = c_byte;
        ram_din  = c_wdata;
        c_ack    = 1'b1;
      end
      GD: begin
        ram_addr = d_addr;
        ram_we   = d_we;
        ram_byte = d_byte;
        ram_din  = d_wdata;
        d_ack    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : single-port RAM arbiter between CPU (C) and DMA (D) with
//               bounded D burst locking
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int D_FIRST   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_we,
  input  logic              c_byte,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic              c_wait,
  input  logic              d_req,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_byte,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int               CNT_W    = burst_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             mux_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // The owner's own req during its ack cycle still names the current access,
  // so it only matters for a locked D burst.
  always_comb begin
    owner_d     = IDLE;
    burst_cnt_d = '0;
    case (owner_q)
      IDLE: begin
        if (c_req && d_req)
          owner_d = (D_FIRST != 0) ? GD : GC;
        else if (c_req)
          owner_d = GC;
        else if (d_req)
          owner_d = GD;
      end
      GC: begin
        if (d_req)
          owner_d = GD;
      end
      GD: begin
        if (d_lock && d_req) begin
          if (c_req && (burst_cnt_q == CNT_LAST)) begin
            owner_d = GC;
          end else begin
            owner_d = GD;
            // Only count while C is actually waiting; saturate rather than wrap.
            if (c_req)
              burst_cnt_d = (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
          end
        end else if (c_req) begin
          owner_d = GC;
        end
      end
      default: owner_d = IDLE;
    endcase
  end

  mem_arb_mux u_mux (
    .owner    (owner_q),
    .c_addr   (c_addr),
    .c_we     (c_we),
    .c_byte   (c_byte),
    .c_wdata  (c_wdata),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_byte   (d_byte),
    .d_wdata  (d_wdata),
    .ram_addr (ram_addr),
    .ram_we   (mux_we),
    .ram_byte (ram_byte),
    .ram_din  (ram_din),
    .c_ack    (c_ack),
    .d_ack    (d_ack)
  );

  // A reset landing on an ack cycle abandons the access, so its write must not commit.
  assign ram_we = mux_we & ~reset;
  assign c_wait = c_req & ~c_ack;
  assign rdata  = ram_dout;

endmodule

`default_nettype wire
